// File: rtl/decoder_pkg.sv
// Shared types and helpers for the binary-to-one-hot decoder stream block.
//   dec_state_t   : skid-buffer occupancy (EMPTY / ONE / TWO)
//   onehot_decode : code -> one-hot word (all-zero when en is low)
// The helper is written for the widest supported code. Callers cast its
// argument and its result to their own widths.
package decoder_pkg;

    localparam int unsigned DEC_MAX_IN_W  = 8;
    localparam int unsigned DEC_MAX_OUT_W = 2 ** DEC_MAX_IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } dec_state_t;

    function automatic logic [DEC_MAX_OUT_W-1:0] onehot_decode(
        input logic [DEC_MAX_IN_W-1:0] code,
        input logic                    en
    );
        logic [DEC_MAX_OUT_W-1:0] w;
        w = '0;
        if (en) begin
            w[code] = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hit_counter_bank.sv
// Bank of N saturating hit counters with a combinational read mux.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : one increment request per counter
//   clr      : synchronous clear of every counter (wins over inc)
//   sel      : counter select for readback
//   val      : combinational value of counter[sel]
module hit_counter_bank #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     inc,
    input  logic             clr,
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] val
);

    logic [CNT_W-1:0] cnt [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                // Saturate at all-ones rather than wrapping.
                if (inc[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign val = cnt[sel];

endmodule

// File: rtl/decoder_2to4_stream.sv
// Registered binary-to-one-hot decoder with valid/ready handshakes.
// A two-entry skid buffer (output register plus skid register) gives full
// throughput under backpressure while in_ready stays a pure register.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready registered)
//   in_code, en         : code to decode and enable, sampled on acceptance
//   out_valid/out_ready : output handshake
//   y                   : one-hot (or all-zero when en was low) word
//   cnt_sel, cnt_val    : per-line hit counter readback
//   cnt_clr             : synchronous clear of all hit counters
module decoder_2to4_stream
    import decoder_pkg::*;
#(
    parameter  int unsigned IN_W  = 2,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    input  logic [IN_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0] cnt_val,
    input  logic             cnt_clr
);

    dec_state_t       state, state_nxt;
    logic [OUT_W-1:0] out_r, skid_r, decoded;
    logic             ready_r;
    logic             accept, xfer;
    logic             load_out, load_skid, skid_to_out;

    assign decoded   = OUT_W'(onehot_decode(DEC_MAX_IN_W'(in_code), en));
    assign accept    = in_valid && ready_r;
    assign xfer      = out_valid && out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = ready_r;
    assign y         = out_r;

    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    state_nxt   = ST_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // in_ready is precomputed from the next state so that it is a flop
    // output with no combinational path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            ready_r <= 1'b1;
            out_r   <= '0;
            skid_r  <= '0;
        end else begin
            state   <= state_nxt;
            ready_r <= (state_nxt != ST_TWO);
            if (load_out) begin
                out_r <= decoded;
            end else if (skid_to_out) begin
                out_r <= skid_r;
            end
            if (load_skid) begin
                skid_r <= decoded;
            end
        end
    end

    // y is one-hot or zero, so it doubles as the per-line increment vector.
    logic [OUT_W-1:0] hit_inc;
    assign hit_inc = xfer ? out_r : '0;

    hit_counter_bank #(
        .N     (OUT_W),
        .SEL_W (IN_W),
        .CNT_W (CNT_W)
    ) u_hits (
        .clk (clk),
        .rst (rst),
        .inc (hit_inc),
        .clr (cnt_clr),
        .sel (cnt_sel),
        .val (cnt_val)
    );

endmodule

// File: tb/tb_decoder_2to4_stream.sv
module tb_decoder_2to4_stream;
    import decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_val;
    logic       cnt_clr;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    int unsigned model_cnt[4];

    decoder_2to4_stream #(.IN_W(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: handshakes are evaluated mid-low-phase, when the
    // values the next rising edge will sample are already settled.
    always @(negedge clk) begin
        logic [3:0] e;
        #2;
        if (!rst) begin
            checks++;
            if (!$onehot0(y)) begin
                errors++;
                $display("FAIL onehot_invariant: y=%b, required one-hot or zero", y);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(4'(onehot_decode(8'(in_code), en)));
            end
            if (cnt_clr) begin
                for (int i = 0; i < 4; i++) model_cnt[i] = 0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: got y=%b, required no word", y);
                end else begin
                    e = exp_q.pop_front();
                    if (y !== e) begin
                        errors++;
                        $display("FAIL scoreboard_order: got y=%b, required %b", y, e);
                    end
                    if (!cnt_clr) begin
                        for (int i = 0; i < 4; i++)
                            if (e[i] && model_cnt[i] < 255) model_cnt[i]++;
                    end
                end
            end
        end
    end

    task automatic clear_models();
        exp_q.delete();
        for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_code = '0; en = 1'b1;
        out_ready = 1'b0; cnt_sel = '0; cnt_clr = 1'b0;
        clear_models();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b y=%b, required 1 0 0000",
                     in_ready, out_valid, y);
        end
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            checks++;
            if (cnt_val !== 8'd0) begin
                errors++;
                $display("FAIL reset_counter[%0d]: got %0d, required 0", i, cnt_val);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [3:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_code = 2'(k); en = 1'b1;
            #1;
            checks++;
            if (k == 0) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL decode_idle: out_valid=%b in_ready=%b, required 0 1",
                             out_valid, in_ready);
                end
            end else begin
                e = 4'b0001 << (k - 1);
                if (out_valid !== 1'b1 || y !== e) begin
                    errors++;
                    $display("FAIL decode_latency[%0d]: out_valid=%b y=%b, required 1 %b",
                             k - 1, out_valid, y, e);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || y !== 4'b1000) begin
            errors++;
            $display("FAIL decode_latency[3]: out_valid=%b y=%b, required 1 1000", out_valid, y);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain: out_valid=%b, required 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            checks++;
            if (cnt_val !== 8'd1) begin
                errors++;
                $display("FAIL decode_counter[%0d]: got %0d, required 1", i, cnt_val);
            end
        end
    endtask

    task automatic test_en_zero();
        @(negedge clk);
        in_valid = 1'b1; in_code = 2'd2; en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || y !== 4'b0000) begin
            errors++;
            $display("FAIL en_zero_word: out_valid=%b y=%b, required 1 0000", out_valid, y);
        end
        repeat (2) @(negedge clk);
        cnt_sel = 2'd2;
        #1;
        checks++;
        if (cnt_val !== 8'd1) begin
            errors++;
            $display("FAIL en_zero_counter: got %0d, required 1", cnt_val);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd1; en = 1'b1;
        @(negedge clk);
        in_code = 2'd3;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 4'b0010) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b y=%b, required 0 1 0010",
                     in_ready, out_valid, y);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (y !== 4'b0010 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: out_valid=%b y=%b, required 1 0010", out_valid, y);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (y !== 4'b1000 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_second: y=%b out_valid=%b in_ready=%b, required 1000 1 1",
                     y, out_valid, in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_code = 2'd1; en = 1'b1;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        cnt_sel = 2'd1;
        #1;
        checks++;
        if (cnt_val !== 8'd255) begin
            errors++;
            $display("FAIL sat_counter: got %0d, required 255", cnt_val);
        end
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; cnt_clr = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_precond: out_valid=%b, required 1", out_valid);
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        checks++;
        if (cnt_val !== 8'd0) begin
            errors++;
            $display("FAIL clr_wins: got %0d, required 0", cnt_val);
        end
        cnt_sel = 2'd3;
        #1;
        checks++;
        if (cnt_val !== 8'd0) begin
            errors++;
            $display("FAIL clr_all: counter[3]=%0d, required 0", cnt_val);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd0; en = 1'b1;
        @(negedge clk);
        in_code = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_precond: in_ready=%b, required 0", in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: out_valid=%b y=%b in_ready=%b, required 0 0000 1",
                     out_valid, y, in_ready);
        end
        clear_models();
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale: out_valid=%b y=%b, required 0", out_valid, y);
            end
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = 2'($urandom_range(0, 3));
            en        = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 499) == 0);
            cnt_sel   = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: %0d words pending, out_valid=%b, required 0 0",
                     exp_q.size(), out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            checks++;
            if (cnt_val !== 8'(model_cnt[i])) begin
                errors++;
                $display("FAIL random_counter[%0d]: got %0d, required %0d", i, cnt_val, model_cnt[i]);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_en_zero();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_2to4_stream.md
Name: decoder_2to4_stream

Overview:
- Registered binary-to-one-hot decoder. It is the inverse of the team's 4-to-2 encoder.
- Accepts a stream of IN_W-bit codes on a valid/ready handshake and emits one-hot OUT_W-bit words downstream.
- A 2-entry skid buffer provides full throughput under backpressure.
- Keeps saturating per-line hit counters for debug and coverage readback.
- Sits between any code producer (encoder, arbiter grant index) and one-hot consumers (select lines, enables).

Parameters:
- IN_W, 2, code width. OUT_W = 2**IN_W is a derived localparam, not overridable.
- CNT_W, 8, width of each per-line hit counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept a code; registered
- in_code  input  IN_W  binary code to decode
- en  input  1  decoder enable, sampled with in_code on input acceptance
- out_valid  output  1  y holds a valid word
- out_ready  input  1  downstream accepts y
- y  output  OUT_W  one-hot (or all-zero) decoded word
- cnt_sel  input  IN_W  selects which hit counter to read
- cnt_val  output  CNT_W  combinational read of counter[cnt_sel]
- cnt_clr  input  1  synchronous clear of all counters

Behaviour:
- Reset (async assert, sync release): in_ready=1, out_valid=0, y=0, skid empty, all counters=0.
- Reset asserted mid-transfer discards any buffered words immediately; nothing is replayed after release.
- Input accepted when in_valid && in_ready.
- Decoded word is 1<<in_code if en=1, else all zeros.
- en=0 words are still transferred (out_valid asserted). They never increment a counter.
- Latency: an accepted code appears on y with out_valid=1 on the next rising edge when the pipe is empty.
- Output transfer when out_valid && out_ready.
- y and out_valid must hold stable while out_valid && !out_ready.
- State machine on buffer occupancy:
  - EMPTY: out_valid=0, in_ready=1.
    - accept -> ONE, word loaded into output register.
  - ONE: out_valid=1, in_ready=1.
    - accept && transfer -> ONE, new word replaces output register.
    - accept && !transfer -> TWO, new word into skid register.
    - !accept && transfer -> EMPTY.
    - neither -> ONE.
  - TWO: out_valid=1, in_ready=0.
    - transfer -> ONE, skid word moves to output register.
    - otherwise -> TWO.
- in_ready is driven from a register (= state != TWO). It has no combinational path from out_ready.
- Sustained in_valid=out_ready=1 yields one word per cycle. There are no bubbles.
- Counters:
  - On each output transfer with y != 0, counter[index of set bit] increments by 1.
  - Counters saturate at 2**CNT_W-1 and do not wrap.
- cnt_clr and an increment in the same cycle: clear wins, so the counter becomes 0.
- cnt_val updates the cycle after an increment or clear.
- Invariant: y is always one-hot or all-zero. The bench asserts this every cycle.

Decomposition:
- Package decoder_pkg:
  - function onehot_decode(code, en) returning the OUT_W word.
  - localparam state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Shared by the RTL and the bench scoreboard.
- One sub-module: hit_counter_bank. It holds OUT_W saturating CNT_W counters with inc vector, clr and sel read mux.

Test Plan:
- Reset, then in_code=0,1,2,3 with en=1 and out_ready=1 held -> y=0001,0010,0100,1000 on consecutive cycles, each one cycle after acceptance. Counters read 1,1,1,1.
- in_code=2 with en=0 -> out_valid=1, y=0000. counter[2] is unchanged.
- out_ready=0 while pushing codes 1 then 3 -> in_ready falls to 0 after the second accept and y holds 0010. Raising out_ready drains 0010 then 1000 in order, and in_ready returns to 1.
- 300 back-to-back in_code=1 transfers -> counter[1] saturates at 255. cnt_clr pulsed in the same cycle as a transfer -> cnt_val=0 the next cycle.
- Assert rst while in state TWO -> out_valid=0, y=0, in_ready=1 immediately (async). No stale word appears after release.
- Random valid/out_ready toggling, 10k cycles -> scoreboard matches the in-order stream exactly. The one-hot/zero invariant is never violated.
